uart_rx_mmio: RTL and testbench
===============================

// Module: uart_rx_mmio
// PURPOSE
//  Memory-mapped UART receiver: the input direction of the CPU's write-only Serial console.
//  Samples an async 8N1 line at 16x oversampling and buffers bytes in a FIFO.
//  The CPU reads the FIFO and status through the Mmu-decoded load path, as for Keyboard/Timer.
// PARAMETERS
//  CLK_HZ      50000000  frequency of clock, Hz
//  BAUD        115200    line rate, bit/s
//  FIFO_DEPTH  16        receive FIFO entries; power of 2, >=2
// PORTS
//  clock    in   1   system clock; all state on rising edge
//  reset    in   1   synchronous, active-high
//  rxd      in   1   async serial line, idle high
//  sel      in   1   Mmu select for this device
//  re       in   1   CPU load strobe
//  addr     in   32  byte address; only addr[2] decoded
//  dout     out  32  read data, combinational from addr and current state
//  rx_ready out  1   FIFO non-empty (registered)
// BEHAVIOUR
//  Reset: rx_ready=0, FIFO empty, all sticky flags 0, FSM=IDLE, synchronizer flops=1.
//    Reset mid-frame aborts the frame; no false start after reset release.
//  rxd passes a 2-flop synchronizer; all decisions use the synced value.
//  Tick: DIV = CLK_HZ/(BAUD*16), rounded to nearest, min 1. One-cycle tick pulse every DIV clocks.
//    Divider is free-running; counter resets on reset only.
//  FSM (advances on ticks; sample counter scnt, 4 bits):
//    IDLE:   synced rxd==0 -> START, scnt=0.
//    START:  at scnt==7 (mid-bit): rxd==0 -> DATA, bit index 0; rxd==1 -> IDLE (glitch rejected).
//    DATA:   sample every 16 ticks at mid-bit; LSB first; after bit 7 -> STOP.
//    STOP:   sample at mid-bit; rxd==1 -> push byte; rxd==0 -> drop byte, set frame_err.
//            Return to IDLE immediately (no wait for bit end), so back-to-back frames are accepted.
//  FIFO:
//    Push while full: byte dropped, overrun set.
//    Pop while empty: no effect.
//    Push and pop in the same cycle: both occur. If full, the push is accepted and count is unchanged.
//  Read map (dout meaningful when sel=1; 0 otherwise):
//    addr[2]=0 DATA:   {23'b0, valid, head_byte}; returns 0 when empty.
//    addr[2]=1 STATUS: {16'b0, count[7:0], 4'b0, parity_err, overrun, frame_err, nonempty}.
//  Pop: on the clock edge ending the FIRST cycle of (sel & re & ~addr[2]).
//    Edge-detected, so a multi-cycle strobe pops exactly once.
//  STATUS read: clears overrun/frame_err/parity_err on the same edge rule.
//    A flag event on that same edge wins, and the flag stays 1.
//  rx_ready is updated one cycle after the push/pop edge.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    Adds PARITY state between DATA and STOP (even parity, sampled at mid-bit).
//    On mismatch the byte is dropped and parity_err set; the STOP check still runs.
//  Undefined: 8N1 only; parity_err reads 0.
// TESTING (sim params CLK_HZ=7372800, BAUD=115200 -> DIV=4, 64 clocks/bit)
//  Frame 0x55 (start,1010_1010 LSB-first,stop):
//    STATUS=0x0000_0101 and rx_ready=1 <=1 bit-time after stop mid-bit; DATA read -> 0x155, then STATUS=0.
//  Glitch: rxd low for 20 clocks, then high -> FSM back to IDLE; FIFO count stays 0.
//  Bad stop: 0xA3 with stop=0 -> no push; STATUS=0x0000_0002; second STATUS read -> 0.
//  Overflow: 17 back-to-back frames 0x00..0x10 -> count=16, overrun=1.
//    16 DATA reads return 0x100..0x10F in order; a 17th DATA read returns 0.
//  Simultaneous events: pop on the same edge a byte is pushed into a full FIFO -> count stays 16, no overrun.
//    Hold re for 3 cycles -> exactly one pop.
//  Reset asserted mid-DATA of 0x3C, released, then 0x7E sent -> only 0x17E read.
//    With UART_RX_PARITY_EN: 0x7E sent with odd parity -> STATUS bit3=1, FIFO empty.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - memory-mapped 16x-oversampling UART receiver with byte FIFO; UART_RX_PARITY_EN adds even parity
module uart_rx_mmio #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rxd,
    input  logic        sel,
    input  logic        re,
    input  logic [31:0] addr,
    output logic [31:0] dout,
    output logic        rx_ready
);
    localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic             data_rd_q, stat_rd_q, rx_ready_q, rx_ready_d;
    logic             tick, push_req, push_ok, pop, clr, full, nonempty;
    logic             frame_ev, overrun_ev, data_rd, stat_rd, parity_flag;
    logic [7:0]       count8;
    logic             unused_addr;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d, parity_err_q, parity_err_d, parity_ev;
`endif

    assign unused_addr = ^{addr[31:3], addr[1:0]};
    assign tick        = (div_cnt_q == DIV_W'(DIV - 1));
    assign div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        frame_ev = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        parity_ev = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        state_d = S_START;
                        scnt_d  = 4'd0;
                    end
                end
                S_START: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd7) begin
                        // Mid-start still low: commit; otherwise it was a glitch.
                        if (!sync2_q) begin
                            state_d = S_DATA;
                            scnt_d  = 4'd0;
                            bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_bad_d = 1'b0;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shift_d = {sync2_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        par_bad_d = (^shift_q) != sync2_q;
                        parity_ev = (^shift_q) != sync2_q;
                        state_d   = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        state_d  = S_IDLE;
                        frame_ev = !sync2_q;
`ifdef UART_RX_PARITY_EN
                        push_req = sync2_q && !par_bad_q;
`else
                        push_req = sync2_q;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pops and flag clears act only on the first cycle of a held strobe.
    always_comb begin
        data_rd     = sel && re && !addr[2];
        stat_rd     = sel && re && addr[2];
        nonempty    = (count_q != '0);
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        pop         = data_rd && !data_rd_q && nonempty;
        clr         = stat_rd && !stat_rd_q;
        push_ok     = push_req && (!full || pop);
        overrun_ev  = push_req && full && !pop;
        count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        overrun_d   = overrun_ev || (overrun_q && !clr);
        frame_err_d = frame_ev || (frame_err_q && !clr);
        rx_ready_d  = nonempty;
        count8      = 8'(count_q);
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_ev || (parity_err_q && !clr);
        parity_flag  = parity_err_q;
`else
        parity_flag  = 1'b0;
`endif
        if (!sel)
            dout = 32'd0;
        else if (addr[2])
            dout = {16'd0, count8, 4'd0, parity_flag, overrun_q, frame_err_q, nonempty};
        else
            dout = {23'd0, nonempty, nonempty ? mem_q[rd_ptr_q] : 8'd0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_cnt_q   <= '0;
            state_q     <= S_IDLE;
            scnt_q      <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_rd_q   <= 1'b0;
            stat_rd_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            data_rd_q   <= data_rd;
            stat_rd_q   <= stat_rd;
            rx_ready_q  <= rx_ready_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_ready = rx_ready_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - randomized self-checking bench for uart_rx_mmio against a queue model
module tb_uart_rx_mmio;
    localparam int BIT_CLKS = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        sel = 1'b0;
    logic        re = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] dout;
    logic        rx_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_q[$];

    uart_rx_mmio #(.CLK_HZ(7372800), .BAUD(115200), .FIFO_DEPTH(16)) dut (
        .clock(clock), .reset(reset), .rxd(rxd), .sel(sel), .re(re),
        .addr(addr), .dout(dout), .rx_ready(rx_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_status(input int cnt, input bit ovr, input bit fe, input bit pe);
        logic [7:0] c8;
        c8 = cnt[7:0];
        return {16'd0, c8, 4'd0, pe, ovr, fe, (cnt != 0)};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_good);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLKS) @(posedge clock);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_good ? ^b : ~(^b);
        repeat (BIT_CLKS) @(posedge clock);
`endif
        rxd = stop;
        repeat (BIT_CLKS) @(posedge clock);
        rxd = 1'b1;
    endtask

    task automatic cpu_read(input logic a2, input int hold, output logic [31:0] v);
        @(negedge clock);
        sel = 1'b1; re = 1'b1; addr = a2 ? 32'd4 : 32'd0;
        #1 v = dout;
        repeat (hold) @(negedge clock);
        sel = 1'b0; re = 1'b0; addr = 32'd0;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clock);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", rx_ready); end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 00000000", v); end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 00000000", v); end
    endtask

    task automatic test_frame_55;
        logic [31:0] v;
        bit seen = 0;
        send_frame(8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (rx_ready === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL f55_rx_ready got 0 exp 1 within bit time"); end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'h0000_0101) begin errors++; $display("FAIL f55_status got %h exp 00000101", v); end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'h0000_0155) begin errors++; $display("FAIL f55_data got %h exp 00000155", v); end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL f55_status_after got %h exp 00000000", v); end
        repeat (3) @(negedge clock);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL f55_rx_ready_clear got %b exp 0", rx_ready); end
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        rxd = 1'b0;
        repeat (20) @(posedge clock);
        idle(2 * BIT_CLKS);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL glitch_status got %h exp 00000000", v); end
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(16);
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'h0000_01A5) begin errors++; $display("FAIL glitch_followup got %h exp 000001a5", v); end
    endtask

    task automatic test_bad_stop;
        logic [31:0] v;
        send_frame(8'hA3, 1'b0, 1'b1);
        idle(2 * BIT_CLKS);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL badstop_status got %h exp 00000002", v); end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL badstop_status2 got %h exp 00000000", v); end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL badstop_data got %h exp 00000000", v); end
    endtask

    task automatic test_random;
        logic [31:0] v;
        logic [7:0]  b;
        bit good;
        bit ferr = 0;
        model_q.delete();
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good, 1'b1);
            if (good) model_q.push_back(b);
            else begin ferr = 1; idle(2 * BIT_CLKS); end
        end
        idle(16);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== exp_status(model_q.size(), 0, ferr, 0)) begin errors++; $display("FAIL rand_status got %h exp %h", v, exp_status(model_q.size(), 0, ferr, 0)); end
        while (model_q.size() > 0) begin
            b = model_q.pop_front();
            cpu_read(1'b0, 1, v);
            checks++; if (v !== {23'd0, 1'b1, b}) begin errors++; $display("FAIL rand_data got %h exp %h", v, {23'd0, 1'b1, b}); end
        end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rand_status_end got %h exp 00000000", v); end
    endtask

    task automatic test_overflow;
        logic [31:0] v;
        for (int k = 0; k <= 16; k++) send_frame(8'(k), 1'b1, 1'b1);
        idle(16);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== exp_status(16, 1, 0, 0)) begin errors++; $display("FAIL ovf_status got %h exp %h", v, exp_status(16, 1, 0, 0)); end
        for (int k = 0; k < 16; k++) begin
            cpu_read(1'b0, 1, v);
            checks++; if (v !== 32'h100 + 32'(k)) begin errors++; $display("FAIL ovf_data got %h exp %h", v, 32'h100 + 32'(k)); end
        end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL ovf_17th got %h exp 00000000", v); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        logic [31:0] popped = 32'd0;
        logic [7:0]  b, x;
        bit hit = 0;
        model_q.delete();
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b1);
            model_q.push_back(b);
        end
        idle(16);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== exp_status(16, 0, 0, 0)) begin errors++; $display("FAIL b2b_full got %h exp %h", v, exp_status(16, 0, 0, 0)); end
        x = 8'($urandom);
        fork
            send_frame(x, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 1200 && !hit; i++) begin
                    @(negedge clock);
                    if (dut.push_req === 1'b1) begin
                        sel = 1'b1; re = 1'b1; addr = 32'd0;
                        #1 popped = dout;
                        hit = 1;
                    end
                end
                repeat (3) @(negedge clock);
                sel = 1'b0; re = 1'b0;
            end
        join
        checks++; if (!hit) begin errors++; $display("FAIL b2b_push_window got none exp a push edge"); end
        b = model_q.pop_front();
        model_q.push_back(x);
        checks++; if (popped !== {23'd0, 1'b1, b}) begin errors++; $display("FAIL b2b_pop_data got %h exp %h", popped, {23'd0, 1'b1, b}); end
        idle(16);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== exp_status(16, 0, 0, 0)) begin errors++; $display("FAIL b2b_status got %h exp %h", v, exp_status(16, 0, 0, 0)); end
        cpu_read(1'b0, 3, v);
        b = model_q.pop_front();
        checks++; if (v !== {23'd0, 1'b1, b}) begin errors++; $display("FAIL b2b_hold_data got %h exp %h", v, {23'd0, 1'b1, b}); end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== exp_status(15, 0, 0, 0)) begin errors++; $display("FAIL b2b_hold_once got %h exp %h", v, exp_status(15, 0, 0, 0)); end
        while (model_q.size() > 0) begin
            b = model_q.pop_front();
            cpu_read(1'b0, 1, v);
            checks++; if (v !== {23'd0, 1'b1, b}) begin errors++; $display("FAIL b2b_drain got %h exp %h", v, {23'd0, 1'b1, b}); end
        end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL b2b_empty got %h exp 00000000", v); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] v;
        logic [7:0]  b = 8'h3C;
        rxd = 1'b0;
        repeat (BIT_CLKS) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            repeat (BIT_CLKS) @(posedge clock);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(2 * BIT_CLKS);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(16);
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'h0000_017E) begin errors++; $display("FAIL rst_mid_data got %h exp 0000017e", v); end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_empty got %h exp 00000000", v); end
        cpu_read(1'b1, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_status got %h exp 00000000", v); end
`ifdef UART_RX_PARITY_EN
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(16);
        cpu_read(1'b1, 1, v);
        checks++; if (v !== exp_status(0, 0, 0, 1)) begin errors++; $display("FAIL parity_status got %h exp %h", v, exp_status(0, 0, 0, 1)); end
        cpu_read(1'b0, 1, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL parity_data got %h exp 00000000", v); end
`endif
    endtask

    initial begin
        repeat (5) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_frame_55();
        test_glitch();
        test_bad_stop();
        test_random();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
